// File: rtl/ray_fixed_pkg.sv
// Shared Q16.16 constants, FSM encoding and component helpers for the hit-normal path.
package ray_fixed_pkg;
   localparam int          FRAC_BITS   = 16;
   localparam logic [31:0] ONE         = 32'h0001_0000;
   localparam logic [31:0] RECIP_SAT   = 32'h7FFF_FFFF;
   localparam int          SQ_STEPS    = 3;
   localparam int          SQRT_STEPS  = 32;
   localparam int          RECIP_STEPS = 32;
   localparam int          SCALE_STEPS = 3;
   localparam logic [4:0]  SQ_LAST     = 5'(SQ_STEPS - 1);
   localparam logic [4:0]  SQRT_LAST   = 5'(SQRT_STEPS - 1);
   localparam logic [4:0]  RECIP_LAST  = 5'(RECIP_STEPS - 1);
   localparam logic [4:0]  SCALE_LAST  = 5'(SCALE_STEPS - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_SQ, ST_SQRT, ST_RECIP, ST_SCALE, ST_DONE} state_e;
   typedef enum logic {MODE_SQRT, MODE_DIV} unit_mode_e;

   // Component idx 0/1/2 = x/y/z of a packed {x,y,z} vector.
   function automatic logic signed [31:0] comp(input logic [95:0] v, input logic [1:0] idx);
      case (idx)
         2'd0:    comp = v[95:64];
         2'd1:    comp = v[63:32];
         default: comp = v[31:0];
      endcase
   endfunction
endpackage

// File: rtl/ray_serial_root_div.sv
// Bit-serial restoring unit: 64b->32b integer sqrt (2 radicand bits/step) or 2^32/divisor (1 bit/step).
module ray_serial_root_div
   import ray_fixed_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  unit_mode_e  mode,
   input  logic        start,
   input  logic        step,
   input  logic [63:0] radicand,
   input  logic [31:0] divisor,
   output logic [31:0] result
);
   logic [63:0] acc, acc_b, acc_n;
   logic [32:0] rem, rem_b, rem_n;
   logic [34:0] shifted, trial;
   logic [31:0] res_b, res_n, dvs, dvs_b;

   // start loads the initial operands and performs the first iteration in the same cycle
   always_comb begin
      acc_b = acc;
      rem_b = rem;
      res_b = result;
      dvs_b = dvs;
      if (start) begin
         acc_b = radicand;
         rem_b = (mode == MODE_DIV) ? 33'd1 : 33'd0;
         res_b = '0;
         dvs_b = divisor;
      end
      if (mode == MODE_SQRT) begin
         shifted = {rem_b, acc_b[63:62]};
         trial   = {1'b0, res_b, 2'b01};
         acc_n   = {acc_b[61:0], 2'b00};
      end else begin
         shifted = {1'b0, rem_b, 1'b0};
         trial   = {3'b000, dvs_b};
         acc_n   = acc_b;
      end
      if (shifted >= trial) begin
         rem_n = 33'(shifted - trial);
         res_n = {res_b[30:0], 1'b1};
      end else begin
         rem_n = shifted[32:0];
         res_n = {res_b[30:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         rem    <= '0;
         result <= '0;
         dvs    <= '0;
      end else if (start || step) begin
         acc    <= acc_n;
         rem    <= rem_n;
         result <= res_n;
         dvs    <= dvs_b;
      end
   end
endmodule

// File: rtl/ray_normal_normalizer.sv
// Normalizes buffered Q16.16 hit normals: square-sum, serial sqrt, serial reciprocal, per-component scale.
module ray_normal_normalizer
   import ray_fixed_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [95:0] hit_normal_unnormalized,
   input  logic        new_data,
   output logic [95:0] hit_normal,
   output logic        output_valid,
   output logic        zero_normal,
   output logic        in_ready,
   output logic        overflow,
   output logic        busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [95:0]         mem [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       count;
   logic                push, pop;
   state_e              state;
   logic [4:0]          cnt, last_cnt;
   logic [95:0]         op;
   logic [63:0]         len_sq;
   logic                zero;
   logic signed [31:0]  nx, ny, mul_a, mul_b, sat;
   logic signed [63:0]  prod, scaled;
   logic [31:0]         unit_res, recip;
   logic                unit_on;

   assign pop      = (state == ST_IDLE) && (count != '0);
   assign in_ready = (count < CW'(FIFO_DEPTH)) || pop;
   assign push     = new_data && in_ready;
   assign busy     = (state != ST_IDLE) || (count != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= hit_normal_unnormalized;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (new_data && !in_ready) overflow <= 1'b1;
      end
   end

   // One multiplier serves both the square-sum and the scale phases.
   assign recip = zero ? RECIP_SAT : unit_res;
   always_comb begin
      mul_a = comp(op, cnt[1:0]);
      mul_b = (state == ST_SCALE) ? signed'(recip) : mul_a;
   end
   assign prod   = mul_a * mul_b;
   assign scaled = prod >>> FRAC_BITS;

   always_comb begin
      if (scaled > 64'sh0000_0000_7FFF_FFFF)      sat = 32'sh7FFF_FFFF;
      else if (scaled < 64'shFFFF_FFFF_8000_0000) sat = 32'sh8000_0000;
      else                                        sat = scaled[31:0];
   end

   always_comb begin
      case (state)
         ST_SQ:    last_cnt = SQ_LAST;
         ST_SQRT:  last_cnt = SQRT_LAST;
         ST_RECIP: last_cnt = RECIP_LAST;
         ST_SCALE: last_cnt = SCALE_LAST;
         default:  last_cnt = '0;
      endcase
   end

   assign unit_on = (state == ST_SQRT) || (state == ST_RECIP);

   ray_serial_root_div u_root_div (
      .clk      (clk),
      .rst      (rst),
      .mode     ((state == ST_RECIP) ? MODE_DIV : MODE_SQRT),
      .start    (unit_on && (cnt == '0)),
      .step     (unit_on && (cnt != '0)),
      .radicand (len_sq),
      .divisor  (unit_res),
      .result   (unit_res)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         op           <= '0;
         len_sq       <= '0;
         zero         <= 1'b0;
         nx           <= '0;
         ny           <= '0;
         hit_normal   <= '0;
         output_valid <= 1'b0;
         zero_normal  <= 1'b0;
      end else begin
         output_valid <= 1'b0;
         if (state != ST_IDLE && state != ST_DONE)
            cnt <= (cnt == last_cnt) ? 5'd0 : cnt + 1'b1;
         case (state)
            ST_IDLE: if (pop) begin
               op     <= mem[rd_ptr];
               len_sq <= '0;
               cnt    <= '0;
               state  <= ST_SQ;
            end
            ST_SQ: begin
               len_sq <= len_sq + $unsigned(prod);
               if (cnt == last_cnt) state <= ST_SQRT;
            end
            ST_SQRT: if (cnt == last_cnt) state <= ST_RECIP;
            ST_RECIP: begin
               // unit still holds the sqrt result on the first divide cycle
               if (cnt == '0) zero <= (unit_res <= 32'd2);
               if (cnt == last_cnt) state <= ST_SCALE;
            end
            ST_SCALE: begin
               if (cnt == 5'd0) nx <= zero ? '0 : sat;
               if (cnt == 5'd1) ny <= zero ? '0 : sat;
               if (cnt == last_cnt) begin
                  hit_normal   <= {nx, ny, (zero ? 32'sd0 : sat)};
                  zero_normal  <= zero;
                  output_valid <= 1'b1;
                  state        <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ray_normal_normalizer.sv
// Random and directed stimulus against an arithmetic reference of unit-normal computation.
module tb_ray_normal_normalizer;
   import ray_fixed_pkg::*;

   logic        clk = 1'b0;
   logic        rst, new_data;
   logic [95:0] hit_normal_unnormalized;
   logic [95:0] hit_normal;
   logic        output_valid, zero_normal, in_ready, overflow, busy;
   int          total = 0, bad = 0, cyc = 0;

   typedef struct {
      logic [95:0] v;
      logic        z;
      int          due;
   } exp_t;
   exp_t expq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ray_normal_normalizer #(.FIFO_DEPTH(4)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .hit_normal_unnormalized (hit_normal_unnormalized),
      .new_data                (new_data),
      .hit_normal              (hit_normal),
      .output_valid            (output_valid),
      .zero_normal             (zero_normal),
      .in_ready                (in_ready),
      .overflow                (overflow),
      .busy                    (busy)
   );

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] sat32(input longint s);
      if (s > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
      if (s < -64'sh8000_0000) return 32'h8000_0000;
      return s[31:0];
   endfunction

   // length = floor(sqrt(sum c^2)); unit = c * floor(2^32/length) / 2^16
   function automatic exp_t model(input logic [95:0] v, input int due);
      longint            c[3];
      longint unsigned   l = 0, r = 0, t, rcp;
      longint            n;
      exp_t              e;
      c[0] = longint'($signed(v[95:64]));
      c[1] = longint'($signed(v[63:32]));
      c[2] = longint'($signed(v[31:0]));
      for (int i = 0; i < 3; i++) l += longint'(c[i] * c[i]);
      for (int b = 31; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t <= l) r = t;
      end
      e.due = due;
      e.z   = (r <= 2);
      e.v   = '0;
      if (!e.z) begin
         rcp = (64'd1 << 32) / r;
         for (int i = 0; i < 3; i++) begin
            n = (c[i] * longint'(rcp)) >>> 16;
            e.v[95-32*i -: 32] = sat32(n);
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (output_valid) begin
         if (expq.size() == 0) chk("spurious_valid", 96'd1, 96'd0);
         else begin
            e = expq.pop_front();
            chk("hit_normal", hit_normal, e.v);
            chk("zero_normal", {95'd0, zero_normal}, {95'd0, e.z});
            chk("latency_cycle", 96'(cyc), 96'(e.due));
         end
      end
   end

   task automatic wait_done(input int budget);
      int i = 0;
      while ((busy || expq.size() != 0) && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk("drain_timeout", {95'd0, (busy || expq.size() != 0)}, 96'd0);
   endtask

   // Single vector into an idle block; due = E0 + 71 where E0 is the next rising edge.
   task automatic one(input logic [95:0] v, input logic [95:0] ev, input logic ez, input string tag);
      exp_t e;
      @(negedge clk);
      e.v = ev; e.z = ez; e.due = cyc + 72;
      expq.push_back(e);
      hit_normal_unnormalized = v;
      new_data = 1'b1;
      @(negedge clk);
      new_data = 1'b0;
      wait_done(300);
      chk({tag, "_hold"}, hit_normal, ev);
   endtask

   function automatic logic [31:0] rnd_comp();
      logic [31:0] m;
      if ($urandom_range(0, 3) == 0) m = 32'($urandom_range(0, 3));
      else m = $urandom >> $urandom_range(1, 20);
      return ($urandom_range(0, 1) == 1) ? -m : m;
   endfunction

   initial begin
      logic [95:0] vb [6];
      logic [95:0] v;
      exp_t        e;
      int          base;

      // new_data while in reset must be ignored
      rst = 1'b1;
      new_data = 1'b1;
      hit_normal_unnormalized = {ONE, 64'd0};
      repeat (4) @(negedge clk);
      rst = 1'b0;
      new_data = 1'b0;
      @(negedge clk);
      chk("rst_hit_normal", hit_normal, 96'd0);
      chk("rst_valid", {95'd0, output_valid}, 96'd0);
      chk("rst_zero", {95'd0, zero_normal}, 96'd0);
      chk("rst_overflow", {95'd0, overflow}, 96'd0);
      chk("rst_busy", {95'd0, busy}, 96'd0);
      chk("idle_in_ready", {95'd0, in_ready}, 96'd1);

      one({ONE, 64'd0}, {ONE, 64'd0}, 1'b0, "unit_x");
      one({32'h0003_0000, 32'h0004_0000, 32'd0}, {32'h0000_9999, 32'h0000_CCCC, 32'd0}, 1'b0, "three_four");
      one({64'd0, 32'hFFFE_0000}, {64'd0, 32'hFFFF_0000}, 1'b0, "neg_z");
      one(96'd0, 96'd0, 1'b1, "all_zero");
      one(96'd1, 96'd0, 1'b1, "one_lsb");
      one({32'd2, 32'd2, 32'd0}, 96'd0, 1'b1, "len_sq8");

      // burst of 6 on consecutive edges: 5 accepted, 6th dropped
      @(negedge clk);
      base = cyc;
      for (int i = 0; i < 6; i++) begin
         vb[i] = {rnd_comp() | 32'h0001_0000, rnd_comp(), rnd_comp()};
         hit_normal_unnormalized = vb[i];
         new_data = 1'b1;
         if (i == 5) begin
            chk("in_ready_full", {95'd0, in_ready}, 96'd0);
            chk("overflow_before_drop", {95'd0, overflow}, 96'd0);
         end else begin
            expq.push_back(model(vb[i], base + 72 + 72 * i));
         end
         @(negedge clk);
      end
      new_data = 1'b0;
      chk("overflow_set", {95'd0, overflow}, 96'd1);
      wait_done(800);
      chk("overflow_sticky", {95'd0, overflow}, 96'd1);

      // reset while in SQRT with two vectors still queued
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         hit_normal_unnormalized = {ONE, ONE, ONE};
         new_data = 1'b1;
         @(negedge clk);
      end
      new_data = 1'b0;
      repeat (8) @(negedge clk);
      chk("busy_before_rst", {95'd0, busy}, 96'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_hit_normal", hit_normal, 96'd0);
      chk("midrst_valid", {95'd0, output_valid}, 96'd0);
      chk("midrst_zero", {95'd0, zero_normal}, 96'd0);
      chk("midrst_overflow", {95'd0, overflow}, 96'd0);
      chk("midrst_busy", {95'd0, busy}, 96'd0);
      repeat (160) @(negedge clk);
      chk("post_rst_idle", {95'd0, busy}, 96'd0);
      one({32'd0, 32'h0002_0000, 32'd0}, {32'd0, ONE, 32'd0}, 1'b0, "after_rst");

      for (int i = 0; i < 24; i++) begin
         v = {rnd_comp(), rnd_comp(), rnd_comp()};
         e = model(v, 0);
         one(v, e.v, e.z, "rnd");
      end
      one({32'd3, 64'd0}, model({32'd3, 64'd0}, 0).v, 1'b0, "len3");
      one({32'h8000_0000, 64'd0}, model({32'h8000_0000, 64'd0}, 0).v, 1'b0, "most_neg");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
